// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared widths, constants and fetch-entry type
package instruction_fetch_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0]       PC_STEP  = 32'd4;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - register-based synchronous FIFO with flush
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Flush resets pointers/count only; stale payload stays in storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, imem request and decoupling buffer to decode
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [INST_WIDTH-1:0] imem_dout,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [XLEN-1:0]       if_pc
);

    logic [XLEN-1:0]             fetch_pc;
    logic                        pop;
    logic                        push;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    fetch_entry_t                wr_entry;
    fetch_entry_t                head_entry;

    assign imem_addr = fetch_pc;
    assign if_valid  = ~fifo_empty;
    assign if_inst   = head_entry.inst;
    assign if_pc     = head_entry.pc;

    // A full buffer can still accept when decode drains the head in the same cycle.
    assign pop  = if_valid & if_ready;
    assign push = fetch_enable & ~redirect_valid & (~fifo_full | pop);

    assign wr_entry.pc   = fetch_pc;
    assign wr_entry.inst = imem_dout;

    logic unused_bits;
    assign unused_bits = &{1'b0, fifo_count, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .din   (wr_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head_entry)
    );

endmodule
